// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR datapath and its capture sink.
package fir_pkg;
  localparam int FIR_DATA_W = 8;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_SKIP,
    CAP_CAPTURE,
    CAP_DONE
  } cap_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter, registered flags and a one-cycle registered read port.
module sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic              wr_accept,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              pop;
  logic [CW-1:0]     count_nxt;

  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign pop       = rd_en && !empty;
  assign wr_accept = wr_en && (!full || pop);
  assign count_nxt = count + CW'(wr_accept) - CW'(pop);

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      rd_valid <= pop;
      count    <= count_nxt;
      full     <= (count_nxt == CW'(DEPTH));
      empty    <= (count_nxt == '0);
    end
  end
endmodule

// File: rtl/fir_capture.sv
// Capture sink behind the FIR: skips leading samples, stores a fixed-length window
// into a FIFO and accumulates the sum of accepted samples.
module fir_capture
  import fir_pkg::*;
#(
  parameter  int DATA_W = FIR_DATA_W,
  parameter  int DEPTH  = 16,
  parameter  int SKIP_W = 4,
  parameter  int LEN_W  = 8,
  localparam int CW     = $clog2(DEPTH) + 1,
  localparam int SW     = DATA_W + LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SKIP_W-1:0] skip,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [SW-1:0]     sum
);
  cap_state_t        state;
  logic [SKIP_W-1:0] skip_cnt;
  logic [LEN_W-1:0]  rem;
  logic              wr_en, wr_accept;

  assign wr_en = (state == CAP_CAPTURE);

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (sample_in),
    .rd_en     (rd_en),
    .wr_accept (wr_accept),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CAP_IDLE;
      skip_cnt <= '0;
      rem      <= '0;
      sum      <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        CAP_IDLE, CAP_DONE: begin
          if (start) begin
            skip_cnt <= skip;
            rem      <= len;
            sum      <= '0;
            overflow <= 1'b0;
            if (len == '0) begin
              state <= CAP_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= (skip != '0) ? CAP_SKIP : CAP_CAPTURE;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        CAP_SKIP: begin
          skip_cnt <= skip_cnt - 1'b1;
          if (skip_cnt == SKIP_W'(1)) state <= CAP_CAPTURE;
        end
        CAP_CAPTURE: begin
          // A dropped sample still consumes a slot of the capture window.
          if (wr_accept) sum <= sum + {{LEN_W{1'b0}}, sample_in};
          else           overflow <= 1'b1;
          rem <= rem - 1'b1;
          if (rem == LEN_W'(1)) begin
            state <= CAP_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= CAP_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fir_capture.sv
// Directed bench for fir_capture: table of capture runs plus hand-written corner sequences.
module tb_fir_capture;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int SKIP_W = 4;
  localparam int LEN_W  = 8;
  localparam int CW     = 5;
  localparam int SW     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [SKIP_W-1:0] skip;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] sample_in;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [CW-1:0]     count;
  logic              full, empty, busy, done, overflow;
  logic [SW-1:0]     sum;

  int checks   = 0;
  int failures = 0;

  fir_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SKIP_W(SKIP_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .skip(skip), .len(len), .sample_in(sample_in),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .full(full),
    .empty(empty), .busy(busy), .done(done), .overflow(overflow), .sum(sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int skip; int len; int base; int step;
    int cnt;  int sum; int ovf;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample presented during the k-th cycle after the start edge is base + step*k.
  task automatic run_capture(input int s, input int l, input int b, input int st);
    int n;
    start = 1'b1; skip = SKIP_W'(s); len = LEN_W'(l); sample_in = '0;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, (l != 0));
    chk("done_after_start", done, (l == 0));
    n = (l == 0) ? 0 : s + l;
    for (int k = 0; k < n; k++) begin
      sample_in = DATA_W'(b + st * k);
      tick();
    end
  endtask

  task automatic drain(input int n, input int b, input int st, input int s);
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, (b + st * (s + i)) & 255);
    end
    rd_en = 1'b0;
    tick();
    chk("rd_valid_idle", rd_valid, 0);
    chk("empty_after_drain", empty, 1);
  endtask

  task automatic run_entry(input int i);
    run_capture(tbl[i].skip, tbl[i].len, tbl[i].base, tbl[i].step);
    chk("done", done, 1);
    chk("busy", busy, 0);
    chk("count", count, tbl[i].cnt);
    chk("sum", sum, tbl[i].sum);
    chk("overflow", overflow, tbl[i].ovf);
    chk("full", full, (tbl[i].cnt == DEPTH));
    chk("empty", empty, (tbl[i].cnt == 0));
    drain(tbl[i].cnt, tbl[i].base, tbl[i].step, tbl[i].skip);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nread;
    tbl[0] = '{skip: 0,  len: 5,  base: 10,  step: 10, cnt: 5,  sum: 150,  ovf: 0};
    tbl[1] = '{skip: 3,  len: 4,  base: 0,   step: 10, cnt: 4,  sum: 180,  ovf: 0};
    tbl[2] = '{skip: 0,  len: 20, base: 1,   step: 1,  cnt: 16, sum: 136,  ovf: 1};
    tbl[3] = '{skip: 2,  len: 0,  base: 9,   step: 1,  cnt: 0,  sum: 0,    ovf: 0};
    tbl[4] = '{skip: 15, len: 1,  base: 3,   step: 2,  cnt: 1,  sum: 33,   ovf: 0};
    tbl[5] = '{skip: 1,  len: 16, base: 200, step: 1,  cnt: 16, sum: 3336, ovf: 0};

    rst = 1'b1; start = 1'b0; skip = '0; len = '0; sample_in = '0; rd_en = 1'b0;
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sum", sum, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_entry(i);

    // Pop every cycle while capturing: occupancy never exceeds one.
    run_capture(0, 20, 1, 1);
    chk("stream_done_early", done, 1);
    run_capture(0, 20, 1, 1);
    nread = 0;
    start = 1'b1; skip = '0; len = 8'd20;
    tick();
    start = 1'b0;
    // Flush the two prior full captures' leftovers first.
    rd_en = 1'b1;
    for (int k = 0; k < 40 && !empty; k++) tick();
    rd_en = 1'b0;
    tick();
    chk("prestream_empty", empty, 1);

    start = 1'b1; skip = '0; len = 8'd20;
    tick();
    start = 1'b0;
    for (int k = 0; k < 21; k++) begin
      sample_in = DATA_W'(1 + k);
      rd_en = 1'b1;
      tick();
      if (rd_valid) begin
        chk("stream_data", rd_data, nread + 1);
        nread++;
      end
    end
    rd_en = 1'b0;
    tick();
    chk("stream_nread", nread, 20);
    chk("stream_overflow", overflow, 0);
    chk("stream_sum", sum, 210);
    chk("stream_done", done, 1);
    chk("stream_empty", empty, 1);

    // Start pulse during CAPTURE is ignored.
    start = 1'b1; skip = '0; len = 8'd6;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin start = 1'b1; skip = 4'd3; len = 8'd2; end
      else start = 1'b0;
      sample_in = DATA_W'(5 + 5 * k);
      tick();
    end
    start = 1'b0;
    chk("ign_done", done, 1);
    chk("ign_count", count, 6);
    chk("ign_sum", sum, 105);
    drain(6, 5, 5, 0);
    rd_en = 1'b1;
    tick();
    chk("empty_rd_valid", rd_valid, 0);
    chk("empty_rd_hold", rd_data, 30);
    rd_en = 1'b0;

    // Reset in the middle of a capture.
    start = 1'b1; skip = '0; len = 8'd10;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample_in = DATA_W'(7 + k);
      tick();
    end
    chk("pre_rst_count", count, 3);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_rd_valid", rd_valid, 0);
    rst = 1'b0;
    tick();
    run_entry(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_capture.md
# fir_capture

Output-side stream sink for the FIR datapath. Samples `filter_out` every clock after a start pulse, discards a programmable number of leading samples (filter latency and transient), stores a programmable number of samples in an internal FIFO, and keeps a running sum of the stored samples. A host or bench drains the FIFO through a registered read handshake. It sits directly behind `fir` and serves as its in-system capture and readback path.

## Interface
- `DATA_W`, 8, sample width; matches the FIR output word.
- `DEPTH`, 16, FIFO entries; power of two, at least 2.
- `SKIP_W`, 4, width of the skip count.
- `LEN_W`, 8, width of the capture length.
- `clk` in, 1, single clock, rising edge.
- `rst` in, 1, reset. Asynchronous, active-high.
- `start` in, 1, one-cycle pulse that arms a capture. Honoured only in IDLE or DONE.
- `skip` in, SKIP_W, number of samples to discard after start. Latched on start.
- `len` in, LEN_W, number of samples to capture. Latched on start.
- `sample_in` in, DATA_W, connects to FIR `filter_out`.
- `rd_en` in, 1, pop request.
- `rd_data` out, DATA_W, popped word.
- `rd_valid` out, 1, qualifies `rd_data`; one-cycle pulse.
- `count` out, $clog2(DEPTH)+1, current FIFO occupancy.
- `full` out, 1, asserted when `count == DEPTH`.
- `empty` out, 1, asserted when `count == 0`.
- `busy` out, 1, high in SKIP or CAPTURE.
- `done` out, 1, high in DONE.
- `overflow` out, 1, sticky flag for a dropped sample.
- `sum` out, DATA_W+LEN_W, unsigned sum of the samples accepted since the last start.

## Operation
- FSM states: IDLE, SKIP, CAPTURE, DONE.
- IDLE or DONE, on `start`:
  - latch `skip` and `len`;
  - clear `sum` and `overflow`;
  - go to SKIP if `skip != 0`, else CAPTURE;
  - if `len == 0`, go straight to DONE.
- SKIP: decrement the skip counter once per cycle; `sample_in` is ignored. When the counter reaches 1, go to CAPTURE. Exactly `skip` cycles are spent in SKIP.
- CAPTURE: each cycle, present `sample_in` as a write and decrement the remaining count. The cycle that handles the last sample transitions to DONE. Exactly `len` cycles are spent in CAPTURE.
- Write while full with no simultaneous pop: the sample is dropped, `overflow` is set, `sum` is unchanged, and the remaining count still decrements.
- Write while full with a simultaneous pop: the write is accepted and `count` is unchanged.
- Accepted write: `sum <= sum + sample_in`, zero-extended. The sum wraps modulo 2^(DATA_W+LEN_W); with the default sizes it cannot wrap.
- `start` in SKIP or CAPTURE is ignored.
- The FIFO is not cleared by `start`. Leftover data remains readable ahead of new data.
- Read: `rd_en && !empty` pops; `rd_data` and `rd_valid` appear on the next cycle.
  - `rd_en` while empty is ignored; `rd_valid` stays 0 and `rd_data` holds its value.
  - Reads are allowed in every state.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked with a separate counter.

## Timing
- Reset values: state IDLE, pointers 0, `count` 0, `empty` 1, `full` 0, `busy` 0, `done` 0, `overflow` 0, `sum` 0, `rd_data` 0, `rd_valid` 0.
- Start at edge N, skip = S, len = L:
  - samples present at edges N+1+S through N+S+L are written;
  - `done` rises after edge N+S+L.
- Flags, `count` and `sum` are registered and update on the edge that performs the write or pop.
- Read latency is 1 cycle, with back-to-back pops at 1 word per cycle.
- Reset asserted mid-capture or mid-read returns everything to the reset values immediately; FIFO contents are don't-care.

## Structure
- A shared package `fir_pkg` holds:
  - the FSM state enum (`CAP_IDLE`, `CAP_SKIP`, `CAP_CAPTURE`, `CAP_DONE`);
  - the default `DATA_W`.
- One sub-module, `sync_fifo`, parameterised by DATA_W and DEPTH. It owns the storage, pointers, count, full/empty flags and the registered read port.
- `fir_capture` owns the FSM, the counters, the sum and the overflow flag.

## Test plan
- Reset, then start with skip=0, len=5, `sample_in` ramp 10,20,…,50 → `done` is set, `count`=5, `sum`=150; five pops return 10,20,30,40,50 with one-cycle `rd_valid` pulses.
- skip=3, len=4, ramp 0,10,…,90 starting the cycle after start → stored 30,40,50,60; `sum`=180.
- len=20, DEPTH=16, no reads, ramp 1..20 → `count`=16, `overflow`=1, `sum`=136, FIFO holds 1..16.
- len=20 with a pop every cycle from the start of CAPTURE → no overflow, all 20 values read in order, `sum`=210.
- Start pulse during CAPTURE → ignored: capture length and `sum` are unchanged. `rd_en` on empty → no `rd_valid`.
- Assert `rst` mid-CAPTURE after 3 writes → next edge shows IDLE, `count`=0, `sum`=0, `overflow`=0, `empty`=1; a subsequent capture works normally.
